add_sub_chunked: RTL and testbench

//  Parametrised multi-cycle two's-complement adder/subtractor; successor to the fixed 8-bit ripple add/sub.

---
 rtl/add_sub_chunked_if.sv | 35 +++
 rtl/add_sub_chunked.sv | 140 ++++++++++++++
 tb/tb_add_sub_chunked.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_chunked_if.sv
// Handshake and data bundle for add_sub_chunked.
//   start    request, honoured only when the unit is idle or finishing (done cycle)
//   addsub   0 = a + b, 1 = a - b; captured with the accepted start
//   a, b     operands, captured with the accepted start
//   busy     high while chunks are being resolved
//   done     one-cycle pulse, result fields valid and held until the next result lands
//   s        result (modulo 2^WIDTH)
//   cout     carry out of the MSB; for subtract 1 means no borrow
//   ov_flag  signed overflow
//   zero     s == 0
// master: requester side. slave: the arithmetic unit.
interface add_sub_chunked_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             addsub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ov_flag;
  logic             zero;

  modport master (
    output start, addsub, a, b,
    input  busy, done, s, cout, ov_flag, zero
  );

  modport slave (
    input  start, addsub, a, b,
    output busy, done, s, cout, ov_flag, zero
  );
endinterface

// File: rtl/add_sub_chunked.sv
// Multi-cycle two's-complement adder/subtractor.
// Resolves CHUNK bits per clock, LSB chunk first, over WIDTH/CHUNK cycles, so the carry chain
// per cycle is only CHUNK bits long. WIDTH must be an integer multiple of CHUNK.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  add_sub_chunked_if.slave: start/addsub/a/b in; busy/done/s/cout/ov_flag/zero out
// Timing: start accepted on edge k -> done high in the cycle after edge k+WIDTH/CHUNK.
// A start seen during the done cycle launches the next operation back-to-back.
module add_sub_chunked #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic            clk,
  input logic            rst,
  add_sub_chunked_if.slave bus
);

  localparam int unsigned NCH      = WIDTH / CHUNK;
  localparam int unsigned IDXW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // already inverted for subtract
  logic [WIDTH-1:0] sum_q, sum_d;  // internal partial sum, never exposed directly
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ov_q, ov_d;
  logic             zero_q, zero_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic             accept;
  int unsigned      base;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             msb_cin;
  logic [WIDTH-1:0] sum_next;

  // Chunk datapath: one CHUNK-bit add per cycle selected by idx_q.
  always_comb begin
    base     = 32'(idx_q) * CHUNK;
    chunk_a  = a_q[base +: CHUNK];
    chunk_b  = b_q[base +: CHUNK];
    {chunk_cout, chunk_sum} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    // Sum bit = a ^ b ^ carry_in, so the carry into the chunk MSB falls out of the XOR.
    msb_cin  = chunk_sum[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
    sum_next = sum_q;
    sum_next[base +: CHUNK] = chunk_sum;
  end

  // Start is honoured in idle and in the done cycle, never while running.
  assign accept = bus.start && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    zero_d  = zero_q;
    idx_d   = idx_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = StRun;
          a_d     = bus.a;
          b_d     = bus.addsub ? ~bus.b : bus.b;
          // Carry-in of 1 completes the two's complement of b.
          carry_d = bus.addsub;
          sum_d   = '0;
          idx_d   = '0;
        end
      end
      StRun: begin
        sum_d   = sum_next;
        carry_d = chunk_cout;
        if (idx_q == LAST_IDX) begin
          state_d = StDone;
          idx_d   = '0;
          s_d     = sum_next;
          cout_d  = chunk_cout;
          ov_d    = msb_cin ^ chunk_cout;
          zero_d  = (sum_next == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.s       = s_q;
  assign bus.cout    = cout_q;
  assign bus.ov_flag = ov_q;
  assign bus.zero    = zero_q;

endmodule

// File: tb/tb_add_sub_chunked.sv
// Bench for add_sub_chunked: three configurations (16/4, 8/8, 32/8) driven from one sequence.
module tb_add_sub_chunked;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ov;
    logic        zero;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  add_sub_chunked_if #(.WIDTH(16)) if16 ();
  add_sub_chunked_if #(.WIDTH(8))  if8  ();
  add_sub_chunked_if #(.WIDTH(32)) if32 ();

  add_sub_chunked #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(if16));
  add_sub_chunked #(.WIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .rst(rst), .bus(if8));
  add_sub_chunked #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .rst(rst), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran too long");
    $fatal(1, "watchdog");
  end

  // Reference: plain modular arithmetic and the signed-overflow sign rule.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic sub);
    res_t        r;
    logic [63:0] mask;
    logic [63:0] full;
    logic        sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    a = a & mask;
    b = b & mask;
    if (!sub) begin
      full   = a + b;
      r.cout = (full > mask);
      r.s    = full & mask;
    end else begin
      r.s    = (a - b) & mask;
      r.cout = (a >= b);
    end
    sa = 1'((a >> (w - 1)) & 64'd1);
    sb = 1'((b >> (w - 1)) & 64'd1);
    ss = 1'((r.s >> (w - 1)) & 64'd1);
    r.ov   = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    r.zero = (r.s == 64'd0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [63:0] av, input logic [63:0] bv,
                       input logic sub);
    case (w)
      16: begin
        if16.start = st; if16.a = av[15:0]; if16.b = bv[15:0]; if16.addsub = sub;
      end
      8: begin
        if8.start = st; if8.a = av[7:0]; if8.b = bv[7:0]; if8.addsub = sub;
      end
      default: begin
        if32.start = st; if32.a = av[31:0]; if32.b = bv[31:0]; if32.addsub = sub;
      end
    endcase
  endtask

  // Drop start and scramble operands: latched values must not be disturbed.
  task automatic release_start(input int w);
    drive(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
  endtask

  function automatic void sample(input int w, output logic dn, output logic bz,
                                 output logic [63:0] sv, output logic co, output logic ov,
                                 output logic zr);
    case (w)
      16: begin
        dn = if16.done; bz = if16.busy; sv = 64'(if16.s);
        co = if16.cout; ov = if16.ov_flag; zr = if16.zero;
      end
      8: begin
        dn = if8.done; bz = if8.busy; sv = 64'(if8.s);
        co = if8.cout; ov = if8.ov_flag; zr = if8.zero;
      end
      default: begin
        dn = if32.done; bz = if32.busy; sv = 64'(if32.s);
        co = if32.cout; ov = if32.ov_flag; zr = if32.zero;
      end
    endcase
  endfunction

  // Called at the negedge right after the accepting edge; expects done after n more cycles.
  task automatic wait_done(input int w, input int n, input string tag);
    int          cyc;
    int          bcyc;
    logic        dn, bz, co, ov, zr;
    logic [63:0] sv;
    cyc  = 0;
    bcyc = 0;
    sample(w, dn, bz, sv, co, ov, zr);
    while (!dn && cyc < 50) begin
      if (bz) bcyc++;
      @(negedge clk);
      cyc++;
      sample(w, dn, bz, sv, co, ov, zr);
    end
    check({tag, "_latency"}, 64'(cyc), 64'(n));
    check({tag, "_busy_cycles"}, 64'(bcyc), 64'(n));
    check({tag, "_busy_in_done"}, 64'(bz), 64'd0);
  endtask

  task automatic check_res(input int w, input logic [63:0] a, input logic [63:0] b,
                           input logic sub, input string tag);
    res_t        r;
    logic        dn, bz, co, ov, zr;
    logic [63:0] sv;
    r = model(w, a, b, sub);
    sample(w, dn, bz, sv, co, ov, zr);
    check({tag, "_done"}, 64'(dn), 64'd1);
    check({tag, "_s"}, sv, r.s);
    check({tag, "_cout"}, 64'(co), 64'(r.cout));
    check({tag, "_ov"}, 64'(ov), 64'(r.ov));
    check({tag, "_zero"}, 64'(zr), 64'(r.zero));
  endtask

  // Full single operation: launch, wait, check result, check pulse width and hold.
  task automatic do_op(input int w, input int nch, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input string tag);
    res_t        r;
    logic        dn, bz, co, ov, zr;
    logic [63:0] sv;
    r = model(w, a, b, sub);
    drive(w, 1'b1, a, b, sub);
    @(negedge clk);
    release_start(w);
    wait_done(w, nch, tag);
    check_res(w, a, b, sub, tag);
    @(negedge clk);
    sample(w, dn, bz, sv, co, ov, zr);
    check({tag, "_pulse"}, 64'(dn), 64'd0);
    check({tag, "_hold"}, sv, r.s);
  endtask

  initial begin
    logic        dn, bz, co, ov, zr;
    logic [63:0] sv;
    logic [63:0] ra, rb;
    logic        rs;
    int          ndone;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(16, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(32, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    sample(16, dn, bz, sv, co, ov, zr);
    check("rst_busy", 64'(bz), 64'd0);
    check("rst_done", 64'(dn), 64'd0);
    check("rst_s", sv, 64'd0);
    check("rst_cout", 64'(co), 64'd0);
    check("rst_ov", 64'(ov), 64'd0);
    check("rst_zero", 64'(zr), 64'd1);
    sample(32, dn, bz, sv, co, ov, zr);
    check("rst32_zero", 64'(zr), 64'd1);

    // Directed boundary cases, 16/4.
    do_op(16, 4, 64'h7FFF, 64'h0001, 1'b0, "add_7fff_1");
    sample(16, dn, bz, sv, co, ov, zr);
    check("add_7fff_1_s_const", sv, 64'h8000);
    check("add_7fff_1_ov_const", 64'(ov), 64'd1);
    do_op(16, 4, 64'hFFFF, 64'h0001, 1'b0, "add_ffff_1");
    sample(16, dn, bz, sv, co, ov, zr);
    check("add_ffff_1_zero_const", 64'(zr), 64'd1);
    check("add_ffff_1_cout_const", 64'(co), 64'd1);
    do_op(16, 4, 64'h0005, 64'h0007, 1'b1, "sub_5_7");
    sample(16, dn, bz, sv, co, ov, zr);
    check("sub_5_7_s_const", sv, 64'hFFFE);

    // Back-to-back: start held into the done cycle launches the second op.
    drive(16, 1'b1, 64'h8000, 64'h0001, 1'b1);
    @(negedge clk);
    release_start(16);
    wait_done(16, 4, "b2b_first");
    check_res(16, 64'h8000, 64'h0001, 1'b1, "b2b_first");
    drive(16, 1'b1, 64'h1234, 64'h1111, 1'b0);
    @(negedge clk);
    release_start(16);
    wait_done(16, 4, "b2b_second");
    check_res(16, 64'h1234, 64'h1111, 1'b0, "b2b_second");
    sample(16, dn, bz, sv, co, ov, zr);
    check("b2b_second_s_const", sv, 64'h2345);
    @(negedge clk);

    // Start pulsed while running is ignored.
    drive(16, 1'b1, 64'h4321, 64'h0FFF, 1'b1);
    @(negedge clk);
    drive(16, 1'b1, 64'hAAAA, 64'h5555, 1'b0);
    @(negedge clk);
    release_start(16);
    wait_done(16, 3, "ign_start");
    check_res(16, 64'h4321, 64'h0FFF, 1'b1, "ign_start");
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      sample(16, dn, bz, sv, co, ov, zr);
      if (dn) ndone++;
    end
    check("ign_start_extra_done", 64'(ndone), 64'd0);

    // Asynchronous reset in the middle of a run.
    drive(16, 1'b1, 64'h0F0F, 64'h0101, 1'b0);
    @(negedge clk);
    release_start(16);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sample(16, dn, bz, sv, co, ov, zr);
    check("arst_busy", 64'(bz), 64'd0);
    check("arst_s", sv, 64'd0);
    check("arst_zero", 64'(zr), 64'd1);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      sample(16, dn, bz, sv, co, ov, zr);
      if (dn) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'd0);
    do_op(16, 4, 64'h1000, 64'h2000, 1'b1, "after_arst");

    // Single-chunk configuration.
    do_op(8, 1, 64'h7F, 64'h01, 1'b0, "w8_add_7f_1");
    sample(8, dn, bz, sv, co, ov, zr);
    check("w8_add_7f_1_s_const", sv, 64'h80);
    do_op(8, 1, 64'h00, 64'h01, 1'b1, "w8_sub_0_1");

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      ra = 64'($urandom);
      rb = (i % 8 == 3) ? ra : 64'($urandom);
      rs = 1'($urandom_range(0, 1));
      do_op(32, 4, ra, rb, rs, $sformatf("rnd32_%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      ra = 64'($urandom_range(0, 16'hFFFF));
      rb = 64'($urandom_range(0, 16'hFFFF));
      rs = 1'($urandom_range(0, 1));
      do_op(16, 4, ra, rb, rs, $sformatf("rnd16_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
